// File: rtl/buffer_sequencer.sv
// Tile sequencer between the unified buffer and a 2x2 array: loads weight and
// input tiles, streams skewed input rows, and stores captured result tiles.
module buffer_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_load_weight,
    input  logic        cmd_load_input,
    input  logic        cmd_store,
    input  logic [12:0] cmd_base_addr,
    output logic        busy,
    output logic        done,
    output logic        cmd_drop,
    output logic [12:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [15:0] mem_wr_data,
    output logic        weight_load,
    output logic [15:0] w00,
    output logic [15:0] w01,
    output logic [15:0] w10,
    output logic [15:0] w11,
    output logic        in_valid,
    output logic [15:0] in_a0,
    output logic [15:0] in_a1,
    input  logic        acc_valid,
    input  logic [15:0] acc0,
    input  logic [15:0] acc1
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_W   = 3'd1;
    localparam logic [2:0] RD_I   = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] WR     = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic [12:0] base;
    logic [15:0] w_tile [4];
    logic [15:0] x_tile [4];
    logic [15:0] r_tile [4];
    logic        row;
    logic        any_cmd;
    logic        capture;
    logic [2:0]  cap_idx;

    assign any_cmd = cmd_load_weight | cmd_load_input | cmd_store;
    // read data for word k arrives while cnt == k+1
    assign capture = (cnt != 3'd0) && (cnt <= 3'd4);
    assign cap_idx = cnt - 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            base     <= '0;
            row      <= 1'b0;
            cmd_drop <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                w_tile[i] <= '0;
                x_tile[i] <= '0;
                r_tile[i] <= '0;
            end
        end else begin
            if (acc_valid) begin
                if (!row) begin
                    r_tile[0] <= acc0;
                    r_tile[1] <= acc1;
                end else begin
                    r_tile[2] <= acc0;
                    r_tile[3] <= acc1;
                end
                row <= ~row;
            end
            if (state != IDLE && any_cmd)
                cmd_drop <= 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_load_weight) begin
                        state <= RD_W;
                        base  <= cmd_base_addr;
                        if (cmd_load_input | cmd_store)
                            cmd_drop <= 1'b1;
                    end else if (cmd_load_input) begin
                        state <= RD_I;
                        base  <= cmd_base_addr;
                        if (cmd_store)
                            cmd_drop <= 1'b1;
                    end else if (cmd_store) begin
                        state <= WR;
                        base  <= cmd_base_addr;
                    end
                end
                RD_W: begin
                    if (capture)
                        w_tile[cap_idx[1:0]] <= mem_rd_data;
                    if (cnt == 3'd5) begin
                        state <= FIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RD_I: begin
                    if (capture)
                        x_tile[cap_idx[1:0]] <= mem_rd_data;
                    if (cnt == 3'd4) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                STREAM: begin
                    if (cnt == 3'd2) begin
                        state <= FIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WR: begin
                    // row pointer restarts after a store, overriding any capture toggle
                    if (cnt == 3'd4) begin
                        state <= FIN;
                        cnt   <= '0;
                        row   <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign weight_load = (state == RD_W) && (cnt == 3'd5);
    assign mem_rd_en   = ((state == RD_W) || (state == RD_I)) && (cnt < 3'd4);
    assign mem_wr_en   = (state == WR) && (cnt < 3'd4);
    assign mem_addr    = (mem_rd_en || mem_wr_en) ? base + {11'd0, cnt[1:0]} : '0;
    assign mem_wr_data = mem_wr_en ? r_tile[cnt[1:0]] : '0;
    assign in_valid    = (state == STREAM);

    assign w00 = w_tile[0];
    assign w01 = w_tile[1];
    assign w10 = w_tile[2];
    assign w11 = w_tile[3];

    // skewed rows: (x00,0), (x10,x01), (0,x11)
    always_comb begin
        in_a0 = '0;
        in_a1 = '0;
        if (state == STREAM) begin
            case (cnt)
                3'd0: in_a0 = x_tile[0];
                3'd1: begin
                    in_a0 = x_tile[2];
                    in_a1 = x_tile[1];
                end
                3'd2: in_a1 = x_tile[3];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_sequencer.sv
// Self-checking bench: a per-cycle expectation timeline built from the command
// rules plus a buffer memory model, with directed and random stimulus.
module tb_buffer_sequencer;

    localparam int N   = 4000;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_load_weight = 1'b0, cmd_load_input = 1'b0, cmd_store = 1'b0;
    logic [12:0] cmd_base_addr = '0;
    logic        busy, done, cmd_drop;
    logic [12:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] mem_wr_data;
    logic        weight_load;
    logic [15:0] w00, w01, w10, w11;
    logic        in_valid;
    logic [15:0] in_a0, in_a1;
    logic        acc_valid = 1'b0;
    logic [15:0] acc0 = '0, acc1 = '0;

    buffer_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_load_weight(cmd_load_weight), .cmd_load_input(cmd_load_input),
        .cmd_store(cmd_store), .cmd_base_addr(cmd_base_addr),
        .busy(busy), .done(done), .cmd_drop(cmd_drop),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .weight_load(weight_load), .w00(w00), .w01(w01), .w10(w10), .w11(w11),
        .in_valid(in_valid), .in_a0(in_a0), .in_a1(in_a1),
        .acc_valid(acc_valid), .acc0(acc0), .acc1(acc1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // unified buffer with one-cycle read latency
    logic [15:0] mem    [8192];
    logic [15:0] refmem [8192];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    logic        e_busy [N], e_done [N], e_rd [N], e_wr [N], e_wl [N], e_inv [N];
    logic [12:0] e_addr [N];
    logic [15:0] e_wdata [N], e_a0 [N], e_a1 [N];
    logic [15:0] e_w [N][4];

    int          busy_end, store_end, drop_cycle, mrow;
    logic [15:0] mres [4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void clear_from(input int c);
        for (int i = c; i < N; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_wr[i] = 0;
            e_wl[i] = 0; e_inv[i] = 0; e_addr[i] = '0; e_wdata[i] = '0;
            e_a0[i] = '0; e_a1[i] = '0;
            for (int k = 0; k < 4; k++) e_w[i][k] = '0;
        end
    endfunction

    function automatic void model_reset(input int c);
        clear_from(c);
        busy_end   = c;
        store_end  = c;
        drop_cycle = BIG;
        mrow       = 0;
        for (int k = 0; k < 4; k++) mres[k] = '0;
    endfunction

    function automatic void sched_load(input int c, input logic [12:0] base, input bit isw);
        logic [15:0] d [4];
        logic [12:0] a;
        int          len;
        for (int k = 0; k < 4; k++) begin
            a = base + 13'(k);
            e_rd[c+1+k]   = 1;
            e_addr[c+1+k] = a;
            d[k]          = refmem[a];
        end
        if (isw) begin
            len = 7;
            e_wl[c+6] = 1;
            for (int k = 0; k < 4; k++) e_w[c+6][k] = d[k];
        end else begin
            len = 9;
            e_inv[c+6] = 1; e_a0[c+6] = d[0]; e_a1[c+6] = '0;
            e_inv[c+7] = 1; e_a0[c+7] = d[2]; e_a1[c+7] = d[1];
            e_inv[c+8] = 1; e_a0[c+8] = '0;   e_a1[c+8] = d[3];
        end
        for (int t = 1; t <= len; t++) e_busy[c+t] = 1;
        e_done[c+len] = 1;
        busy_end = c + len;
    endfunction

    function automatic void sched_store(input int c, input logic [12:0] base);
        logic [12:0] a;
        for (int k = 0; k < 4; k++) begin
            a = base + 13'(k);
            e_wr[c+1+k]    = 1;
            e_addr[c+1+k]  = a;
            e_wdata[c+1+k] = mres[k];
            refmem[a]      = mres[k];
        end
        for (int t = 1; t <= 6; t++) e_busy[c+t] = 1;
        e_done[c+6] = 1;
        busy_end  = c + 6;
        store_end = c + 6;
        mrow      = 0;
    endfunction

    function automatic void note_drop(input int c);
        if (c + 1 < drop_cycle) drop_cycle = c + 1;
    endfunction

    // Applies one cycle of inputs and records what they imply for later cycles.
    task automatic drive(input bit cw, input bit ci, input bit cs, input logic [12:0] base,
                         input bit av, input logic [15:0] a0, input logic [15:0] a1);
        int c;
        bit st_acc;
        bit av_eff;
        c = cyc;
        st_acc = (c > busy_end) && cs && !cw && !ci;
        av_eff = av && !st_acc && (c > store_end) && !reset;
        cmd_load_weight = cw; cmd_load_input = ci; cmd_store = cs;
        cmd_base_addr = base; acc_valid = av_eff; acc0 = a0; acc1 = a1;
        if ((cw || ci || cs) && !reset) begin
            if (c <= busy_end) note_drop(c);
            else if (cw) begin
                if (ci || cs) note_drop(c);
                sched_load(c, base, 1'b1);
            end else if (ci) begin
                if (cs) note_drop(c);
                sched_load(c, base, 1'b0);
            end else begin
                sched_store(c, base);
            end
        end
        if (av_eff) begin
            mres[mrow*2]   = a0;
            mres[mrow*2+1] = a1;
            mrow ^= 1;
        end
    endtask

    task automatic step_cmd(input bit cw, input bit ci, input bit cs, input logic [12:0] base,
                            input bit av, input logic [15:0] a0, input logic [15:0] a1);
        @(posedge clk);
        #1;
        drive(cw, ci, cs, base, av, a0, a1);
    endtask

    task automatic step_idle();
        step_cmd(0, 0, 0, '0, 0, '0, '0);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step_idle();
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("mem_rd_en", mem_rd_en, e_rd[cyc]);
            chk("mem_wr_en", mem_wr_en, e_wr[cyc]);
            chk("weight_load", weight_load, e_wl[cyc]);
            chk("in_valid", in_valid, e_inv[cyc]);
            chk("in_a0", in_a0, e_a0[cyc]);
            chk("in_a1", in_a1, e_a1[cyc]);
            chk("cmd_drop", cmd_drop, int'(cyc >= drop_cycle));
            if (e_rd[cyc] || e_wr[cyc]) chk("mem_addr", mem_addr, e_addr[cyc]);
            if (e_wr[cyc]) chk("mem_wr_data", mem_wr_data, e_wdata[cyc]);
            if (e_wl[cyc]) begin
                chk("w00", w00, e_w[cyc][0]);
                chk("w01", w01, e_w[cyc][1]);
                chk("w10", w10, e_w[cyc][2]);
                chk("w11", w11, e_w[cyc][3]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int r;
        bit cw, ci, cs, av;
        logic [12:0] base;

        for (int i = 0; i < 8192; i++) begin
            mem[i]    = 16'(i * 37 + 11);
            refmem[i] = mem[i];
        end
        for (int k = 0; k < 4; k++) begin
            mem[16'h10 + k] = 16'(k + 1);  refmem[16'h10 + k] = 16'(k + 1);
            mem[16'h20 + k] = 16'(k + 5);  refmem[16'h20 + k] = 16'(k + 5);
        end
        model_reset(0);

        step_idle();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_drop", cmd_drop, 0);
        chk("reset_w00", w00, 0);
        chk("reset_addr", mem_addr, 0);
        step_idle();
        reset = 1'b0;
        step_idle();

        // weight tile 1,2,3,4 from 0x0010
        step_cmd(1, 0, 0, 13'h0010, 0, '0, '0);
        c0 = cyc;
        run_to(c0 + 1); @(negedge clk); chk("lw_addr0", mem_addr, 16'h10);
        run_to(c0 + 6); @(negedge clk);
        chk("lw_wl", weight_load, 1);
        chk("lw_w00", w00, 1); chk("lw_w01", w01, 2);
        chk("lw_w10", w10, 3); chk("lw_w11", w11, 4);
        run_to(c0 + 7); @(negedge clk); chk("lw_done", done, 1);
        run_to(c0 + 8);

        // input tile 5,6,7,8 from 0x0020
        step_cmd(0, 1, 0, 13'h0020, 0, '0, '0);
        c0 = cyc;
        run_to(c0 + 6); @(negedge clk); chk("li_a0_0", in_a0, 5); chk("li_a1_0", in_a1, 0);
        run_to(c0 + 7); @(negedge clk); chk("li_a0_1", in_a0, 7); chk("li_a1_1", in_a1, 6);
        run_to(c0 + 8); @(negedge clk); chk("li_a0_2", in_a0, 0); chk("li_a1_2", in_a1, 8);
        run_to(c0 + 9); @(negedge clk); chk("li_done", done, 1);
        run_to(c0 + 10);

        // results (9,10),(11,12) stored to 0x0100
        step_cmd(0, 0, 0, '0, 1, 16'd9, 16'd10);
        step_cmd(0, 0, 0, '0, 1, 16'd11, 16'd12);
        step_cmd(0, 0, 1, 13'h0100, 0, '0, '0);
        c0 = cyc;
        run_to(c0 + 6); @(negedge clk); chk("st_done", done, 1);
        run_to(c0 + 7);
        for (int k = 0; k < 4; k++) chk("st_mem", mem[16'h100 + k], 9 + k);

        // address wrap from 0x1FFE
        step_cmd(1, 0, 0, 13'h1FFE, 0, '0, '0);
        c0 = cyc;
        run_to(c0 + 2); @(negedge clk); chk("wrap_1fff", mem_addr, 16'h1FFF);
        run_to(c0 + 3); @(negedge clk); chk("wrap_0000", mem_addr, 0);
        run_to(c0 + 4); @(negedge clk); chk("wrap_0001", mem_addr, 1);
        run_to(c0 + 8);

        // simultaneous weight+store, then store while busy
        step_cmd(1, 0, 1, 13'h0040, 0, '0, '0);
        c0 = cyc;
        step_idle(); @(negedge clk); chk("drop_set", cmd_drop, 1);
        step_cmd(0, 0, 1, 13'h0080, 0, '0, '0);
        run_to(c0 + 8); @(negedge clk);
        chk("drop_sticky", cmd_drop, 1);
        chk("drop_no_wr", mem[16'h80], refmem[16'h80]);

        // reset during third STREAM cycle, then a normal weight load
        step_cmd(0, 1, 0, 13'h0020, 0, '0, '0);
        c0 = cyc;
        run_to(c0 + 8);
        reset = 1'b1;
        model_reset(cyc);
        #1;
        chk("rst_busy", busy, 0); chk("rst_inv", in_valid, 0);
        chk("rst_a1", in_a1, 0); chk("rst_drop", cmd_drop, 0);
        step_idle(); step_idle();
        reset = 1'b0;
        run_to(c0 + 12);
        step_cmd(1, 0, 0, 13'h0010, 0, '0, '0);
        c0 = cyc;
        run_to(c0 + 6); @(negedge clk); chk("post_w00", w00, 1); chk("post_w11", w11, 4);
        run_to(c0 + 7); @(negedge clk); chk("post_done", done, 1);
        run_to(c0 + 8);

        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 9);
            cw = (r == 0); ci = (r == 1); cs = (r == 2);
            if (r == 3) begin
                cw = $urandom_range(0, 1) == 1;
                ci = $urandom_range(0, 1) == 1;
                cs = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 3) == 0) base = 13'h1FFC + 13'($urandom_range(0, 3));
            else base = 13'($urandom_range(0, 8191));
            av = $urandom_range(0, 3) == 0;
            step_cmd(cw, ci, cs, base, av, 16'($urandom), 16'($urandom));
        end
        run_to(cyc + 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
